dnn_infer_ctrl: RTL

//  Sequencer for the fixed-point sigmoid inference engine and its 10-way output selector.
//  Per request: latch an image index and drive the engine's image base address.

---
 rtl/dnn_infer_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dnn_infer_ctrl.sv
// dnn_infer_ctrl: request sequencer for the sigmoid inference engine.
// Clears and starts the engine, waits for done, returns the argmax class.
`timescale 1ns/1ps
module dnn_infer_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 2,
  parameter int IMG_W       = 8,
  parameter int IMG_STRIDE  = 1024,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [IMG_W-1:0]      req_img,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [3:0]            rsp_digit,
  output logic [DATA_WIDTH-1:0] rsp_score,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] img_base,
  output logic                  eng_reset,
  output logic                  eng_start,
  input  logic                  eng_done,
  output logic [3:0]            eng_out_idx,
  input  logic [DATA_WIDTH-1:0] eng_out,
  output logic                  busy
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_WAIT,
    S_SCAN,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]                cnt;
  logic                         tc;
  logic                         last;
  logic                         take;
  logic signed [DATA_WIDTH-1:0] score_in;
  logic signed [DATA_WIDTH-1:0] best;
  logic [3:0]                   best_idx;
  logic [ADDR_WIDTH-1:0]        base_nx;

  assign base_nx  = ADDR_WIDTH'(32'(req_img) * 32'(IMG_STRIDE));
  assign score_in = eng_out;
  assign tc       = (cnt == TC_LAST);
  assign last     = (eng_out_idx == 4'd9);
  // idx 0 always seeds; later only strictly greater wins
  assign take     = (eng_out_idx == 4'd0) || (score_in > best);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // next-state logic; done has priority over terminal count
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (req_valid) state_nx = S_CLEAR;
      S_CLEAR: state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        if (eng_done)  state_nx = S_SCAN;
        else if (tc)   state_nx = S_RESP;
      end
      S_SCAN:  if (last) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Moore handshake and engine strobes
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    eng_reset = 1'b0;
    eng_start = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_CLEAR: eng_reset = 1'b1;
      S_START: eng_start = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // datapath: base latch, timeout counter, argmax scan, result hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_base    <= '0;
      cnt         <= '0;
      eng_out_idx <= '0;
      best        <= '0;
      best_idx    <= '0;
      rsp_digit   <= '0;
      rsp_score   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) img_base <= base_nx;
        end
        S_START: begin
          cnt         <= '0;
          eng_out_idx <= '0;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (!eng_done && tc) begin
            rsp_timeout <= 1'b1;
            rsp_digit   <= 4'hF;
            rsp_score   <= '0;
          end
        end
        S_SCAN: begin
          if (take) begin
            best     <= score_in;
            best_idx <= eng_out_idx;
          end
          if (last) begin
            eng_out_idx <= '0;
            rsp_timeout <= 1'b0;
            rsp_digit   <= take ? eng_out_idx : best_idx;
            rsp_score   <= take ? score_in : best;
          end else begin
            eng_out_idx <= eng_out_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
